// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the integer core write-back path
// Purpose: register file geometry and the write-back skid FSM state encoding.
// Ports: none (package).
package core_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int PTR_W = 5;

    typedef enum logic [1:0] {
        SKID_EMPTY  = 2'd0,
        SKID_HELD   = 2'd1,
        SKID_URGENT = 2'd2
    } skid_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard for the integer register file
// Purpose: one pending bit per architectural register (x0 never pending).
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   set_en_i, set_ptr_i    mark a destination pending (issue)
//   clr_en_i, clr_ptr_i    retire a destination (register file write completed)
//   rs1_ptr_i, rs2_ptr_i   decode source pointers
//   rd_ptr_i               decode destination pointer
//   hazard_o               any of the three pointers is pending
//   busy_o                 any bit pending
module wb_scoreboard #(
    parameter int NREG  = core_pkg::NREG,
    parameter int PTR_W = core_pkg::PTR_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_en_i,
    input  logic [PTR_W-1:0] set_ptr_i,
    input  logic             clr_en_i,
    input  logic [PTR_W-1:0] clr_ptr_i,
    input  logic [PTR_W-1:0] rs1_ptr_i,
    input  logic [PTR_W-1:0] rs2_ptr_i,
    input  logic [PTR_W-1:0] rd_ptr_i,
    output logic             hazard_o,
    output logic             busy_o
);
    import core_pkg::*;

    localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[set_ptr_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_ptr_i] = 1'b1;
    end

    // Set is ORed in after the clear so a same-cycle re-issue keeps the bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= ((pend_q & ~clr_mask) | set_mask) & X0_MASK;
        end
    end

    assign hazard_o = pend_q[rs1_ptr_i] | pend_q[rs2_ptr_i] | pend_q[rd_ptr_i];
    assign busy_o   = |pend_q;

`ifndef SYNTHESIS
    // A write to a register nobody is waiting on is legal but suspicious.
    always @(posedge clk_i) begin
        if (!rst_i && clr_en_i && (clr_ptr_i != '0)) begin
            assert (pend_q[clr_ptr_i])
                else $warning("wb_scoreboard: write to non-pending register %0d", clr_ptr_i);
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-port arbiter for the integer register file
// Purpose: merges ALU and mem results into one registered write stream, with a
//          1-entry ALU skid buffer and a pending-write scoreboard for decode.
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   issue_valid_i, issue_rd_ptr_i        decode issue of a writing instruction
//   rs1_ptr_i, rs2_ptr_i                 decode source pointers
//   hazard_o, busy_o                     scoreboard stall / any-pending
//   alu_valid_i/ready_o/rd_ptr_i/data_i  ALU result handshake
//   mem_valid_i/ready_o/rd_ptr_i/data_i  load / multi-cycle result handshake
//   reg_write_en_o, rd_ptr_o, rd_o       registered register file write port
module wb_arbiter #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREG  = core_pkg::NREG,
    parameter int PTR_W = core_pkg::PTR_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic [PTR_W-1:0] issue_rd_ptr_i,
    input  logic [PTR_W-1:0] rs1_ptr_i,
    input  logic [PTR_W-1:0] rs2_ptr_i,
    output logic             hazard_o,
    output logic             busy_o,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [PTR_W-1:0] alu_rd_ptr_i,
    input  logic [XLEN-1:0]  alu_data_i,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic [PTR_W-1:0] mem_rd_ptr_i,
    input  logic [XLEN-1:0]  mem_data_i,
    output logic             reg_write_en_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [XLEN-1:0]  rd_o
);
    import core_pkg::*;

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic [PTR_W-1:0] skid_ptr_q;
    logic [XLEN-1:0]  skid_data_q;

    logic             sel_valid;
    logic [PTR_W-1:0] sel_ptr;
    logic [XLEN-1:0]  sel_data;
    logic             skid_load;
    logic             do_write;

    // Readies depend on state only, so neither source sees a combinational
    // path from the other's valid.
    assign alu_ready_o = (state_q == SKID_EMPTY);
    assign mem_ready_o = (state_q != SKID_URGENT);

    // Mem wins a collision; the ALU result parks in the skid. After one more
    // mem win the skid is forced out (URGENT), so it waits at most 2 cycles.
    always_comb begin
        state_d   = state_q;
        sel_valid = 1'b0;
        sel_ptr   = mem_rd_ptr_i;
        sel_data  = mem_data_i;
        skid_load = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (mem_valid_i) begin
                    sel_valid = 1'b1;
                    if (alu_valid_i) begin
                        skid_load = 1'b1;
                        state_d   = SKID_HELD;
                    end
                end else if (alu_valid_i) begin
                    sel_valid = 1'b1;
                    sel_ptr   = alu_rd_ptr_i;
                    sel_data  = alu_data_i;
                end
            end
            SKID_HELD: begin
                sel_valid = 1'b1;
                if (mem_valid_i) begin
                    state_d = SKID_URGENT;
                end else begin
                    sel_ptr  = skid_ptr_q;
                    sel_data = skid_data_q;
                    state_d  = SKID_EMPTY;
                end
            end
            SKID_URGENT: begin
                sel_valid = 1'b1;
                sel_ptr   = skid_ptr_q;
                sel_data  = skid_data_q;
                state_d   = SKID_EMPTY;
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // x0 results complete their handshake but never reach the register file.
    assign do_write = sel_valid && (sel_ptr != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= SKID_EMPTY;
            skid_ptr_q     <= '0;
            skid_data_q    <= '0;
            reg_write_en_o <= 1'b0;
            rd_ptr_o       <= '0;
            rd_o           <= '0;
        end else begin
            state_q        <= state_d;
            reg_write_en_o <= do_write;
            if (skid_load) begin
                skid_ptr_q  <= alu_rd_ptr_i;
                skid_data_q <= alu_data_i;
            end
            if (do_write) begin
                rd_ptr_o <= sel_ptr;
                rd_o     <= sel_data;
            end
        end
    end

    // The register file writes on the falling edge inside the reg_write_en_o
    // cycle, so the pending bit retires on the following rising edge.
    wb_scoreboard #(
        .NREG  (NREG),
        .PTR_W (PTR_W)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_en_i  (issue_valid_i),
        .set_ptr_i (issue_rd_ptr_i),
        .clr_en_i  (reg_write_en_o),
        .clr_ptr_i (rd_ptr_o),
        .rs1_ptr_i (rs1_ptr_i),
        .rs2_ptr_i (rs2_ptr_i),
        .rd_ptr_i  (issue_rd_ptr_i),
        .hazard_o  (hazard_o),
        .busy_o    (busy_o)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_ptr_i;
    logic [4:0]  rs1_ptr_i;
    logic [4:0]  rs2_ptr_i;
    logic        hazard_o;
    logic        busy_o;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_ptr_i;
    logic [31:0] alu_data_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_ptr_i;
    logic [31:0] mem_data_i;
    logic        reg_write_en_o;
    logic [4:0]  rd_ptr_o;
    logic [31:0] rd_o;

    int checks = 0;
    int failures = 0;

    wb_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_ptr_i (issue_rd_ptr_i),
        .rs1_ptr_i      (rs1_ptr_i),
        .rs2_ptr_i      (rs2_ptr_i),
        .hazard_o       (hazard_o),
        .busy_o         (busy_o),
        .alu_valid_i    (alu_valid_i),
        .alu_ready_o    (alu_ready_o),
        .alu_rd_ptr_i   (alu_rd_ptr_i),
        .alu_data_i     (alu_data_i),
        .mem_valid_i    (mem_valid_i),
        .mem_ready_o    (mem_ready_o),
        .mem_rd_ptr_i   (mem_rd_ptr_i),
        .mem_data_i     (mem_data_i),
        .reg_write_en_o (reg_write_en_o),
        .rd_ptr_o       (rd_ptr_o),
        .rd_o           (rd_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Decode must never issue while stalled.
    always @(negedge clk_i) begin
        if (!rst_i && issue_valid_i && hazard_o) begin
            failures++;
            $display("FAIL issue_under_hazard got=1 exp=0 rd=%0d", issue_rd_ptr_i);
        end
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        issue_valid_i = 1'b0; issue_rd_ptr_i = '0;
        rs1_ptr_i = '0; rs2_ptr_i = '0;
        alu_valid_i = 1'b0; alu_rd_ptr_i = '0; alu_data_i = '0;
        mem_valid_i = 1'b0; mem_rd_ptr_i = '0; mem_data_i = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid_i = 1'b1; issue_rd_ptr_i = rd;
        step();
        issue_valid_i = 1'b0; issue_rd_ptr_i = '0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        clear_inputs();
        step(); step();
        checks++; if (reg_write_en_o !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0b exp=0", reg_write_en_o); end
        checks++; if (rd_ptr_o !== 5'd0) begin failures++; $display("FAIL rst_rd_ptr got=%0d exp=0", rd_ptr_o); end
        checks++; if (rd_o !== 32'h0) begin failures++; $display("FAIL rst_rd got=%h exp=0", rd_o); end
        checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL rst_hazard got=%0b exp=0", hazard_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
        checks++; if (alu_ready_o !== 1'b1) begin failures++; $display("FAIL rst_alu_ready got=%0b exp=1", alu_ready_o); end
        checks++; if (mem_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mem_ready got=%0b exp=1", mem_ready_o); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_alu_only;
        issue(5'd5);
        rs1_ptr_i = 5'd5;
        checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL alu_hazard_pending got=%0b exp=1", hazard_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL alu_busy got=%0b exp=1", busy_o); end
        alu_valid_i = 1'b1; alu_rd_ptr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        checks++; if (alu_ready_o !== 1'b1) begin failures++; $display("FAIL alu_ready got=%0b exp=1", alu_ready_o); end
        step();
        alu_valid_i = 1'b0;
        checks++; if (reg_write_en_o !== 1'b1) begin failures++; $display("FAIL alu_wr_en got=%0b exp=1", reg_write_en_o); end
        checks++; if (rd_ptr_o !== 5'd5) begin failures++; $display("FAIL alu_rd_ptr got=%0d exp=5", rd_ptr_o); end
        checks++; if (rd_o !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_rd got=%h exp=deadbeef", rd_o); end
        checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL alu_hazard_pulse got=%0b exp=1", hazard_o); end
        step();
        checks++; if (reg_write_en_o !== 1'b0) begin failures++; $display("FAIL alu_wr_en_single got=%0b exp=0", reg_write_en_o); end
        checks++; if (rd_ptr_o !== 5'd5 || rd_o !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_hold got=%0d/%h exp=5/deadbeef", rd_ptr_o, rd_o); end
        checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL alu_hazard_retired got=%0b exp=0", hazard_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL alu_busy_retired got=%0b exp=0", busy_o); end
        rs1_ptr_i = '0;
    endtask

    task automatic test_collision;
        issue(5'd3);
        issue(5'd4);
        alu_valid_i = 1'b1; alu_rd_ptr_i = 5'd3; alu_data_i = 32'h11;
        mem_valid_i = 1'b1; mem_rd_ptr_i = 5'd4; mem_data_i = 32'h22;
        checks++; if (alu_ready_o !== 1'b1 || mem_ready_o !== 1'b1) begin failures++; $display("FAIL col_ready got=%0b%0b exp=11", alu_ready_o, mem_ready_o); end
        step();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd4 || rd_o !== 32'h22) begin failures++; $display("FAIL col_first got=%0b/%0d/%h exp=1/4/22", reg_write_en_o, rd_ptr_o, rd_o); end
        checks++; if (alu_ready_o !== 1'b0 || mem_ready_o !== 1'b1) begin failures++; $display("FAIL col_held_ready got=%0b%0b exp=01", alu_ready_o, mem_ready_o); end
        step();
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd3 || rd_o !== 32'h11) begin failures++; $display("FAIL col_second got=%0b/%0d/%h exp=1/3/11", reg_write_en_o, rd_ptr_o, rd_o); end
        checks++; if (alu_ready_o !== 1'b1) begin failures++; $display("FAIL col_empty_ready got=%0b exp=1", alu_ready_o); end
        step();
        checks++; if (reg_write_en_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL col_done got=%0b/%0b exp=0/0", reg_write_en_o, busy_o); end
    endtask

    task automatic test_starvation;
        for (int i = 10; i <= 13; i++) issue(5'(i));
        alu_valid_i = 1'b1; alu_rd_ptr_i = 5'd10; alu_data_i = 32'hA0;
        mem_valid_i = 1'b1; mem_rd_ptr_i = 5'd11; mem_data_i = 32'hB1;
        step();
        alu_valid_i = 1'b0;
        mem_rd_ptr_i = 5'd12; mem_data_i = 32'hB2;
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd11 || rd_o !== 32'hB1) begin failures++; $display("FAIL stv_w1 got=%0b/%0d/%h exp=1/11/b1", reg_write_en_o, rd_ptr_o, rd_o); end
        checks++; if (mem_ready_o !== 1'b1 || alu_ready_o !== 1'b0) begin failures++; $display("FAIL stv_held_ready got=%0b%0b exp=10", mem_ready_o, alu_ready_o); end
        step();
        mem_rd_ptr_i = 5'd13; mem_data_i = 32'hB3;
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd12 || rd_o !== 32'hB2) begin failures++; $display("FAIL stv_w2 got=%0b/%0d/%h exp=1/12/b2", reg_write_en_o, rd_ptr_o, rd_o); end
        checks++; if (mem_ready_o !== 1'b0 || alu_ready_o !== 1'b0) begin failures++; $display("FAIL stv_urgent_ready got=%0b%0b exp=00", mem_ready_o, alu_ready_o); end
        step();
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd10 || rd_o !== 32'hA0) begin failures++; $display("FAIL stv_w3 got=%0b/%0d/%h exp=1/10/a0", reg_write_en_o, rd_ptr_o, rd_o); end
        checks++; if (mem_ready_o !== 1'b1 || alu_ready_o !== 1'b1) begin failures++; $display("FAIL stv_empty_ready got=%0b%0b exp=11", mem_ready_o, alu_ready_o); end
        step();
        mem_valid_i = 1'b0;
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd13 || rd_o !== 32'hB3) begin failures++; $display("FAIL stv_w4 got=%0b/%0d/%h exp=1/13/b3", reg_write_en_o, rd_ptr_o, rd_o); end
        step();
        checks++; if (reg_write_en_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL stv_done got=%0b/%0b exp=0/0", reg_write_en_o, busy_o); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) issue(5'(20 + i));
        for (int i = 0; i < 3; i++) begin
            alu_valid_i = 1'b1; alu_rd_ptr_i = 5'(20 + i); alu_data_i = 32'(256 + i);
            step();
            checks++;
            if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'(20 + i) || rd_o !== 32'(256 + i)) begin
                failures++; $display("FAIL b2b_w%0d got=%0b/%0d/%h exp=1/%0d/%h", i, reg_write_en_o, rd_ptr_o, rd_o, 20 + i, 256 + i);
            end
        end
        alu_valid_i = 1'b0;
        step();
        checks++; if (reg_write_en_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL b2b_done got=%0b/%0b exp=0/0", reg_write_en_o, busy_o); end
        checks++; if (rd_ptr_o !== 5'd22 || rd_o !== 32'h102) begin failures++; $display("FAIL b2b_hold got=%0d/%h exp=22/102", rd_ptr_o, rd_o); end
    endtask

    task automatic test_x0;
        issue(5'd0);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL x0_issue_busy got=%0b exp=0", busy_o); end
        issue(5'd9);
        mem_valid_i = 1'b1; mem_rd_ptr_i = 5'd0; mem_data_i = 32'hFFFFFFFF;
        checks++; if (mem_ready_o !== 1'b1) begin failures++; $display("FAIL x0_mem_ready got=%0b exp=1", mem_ready_o); end
        step();
        mem_valid_i = 1'b0;
        checks++; if (reg_write_en_o !== 1'b0) begin failures++; $display("FAIL x0_wr_en got=%0b exp=0", reg_write_en_o); end
        checks++; if (rd_ptr_o !== 5'd22 || rd_o !== 32'h102) begin failures++; $display("FAIL x0_hold got=%0d/%h exp=22/102", rd_ptr_o, rd_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL x0_busy got=%0b exp=1", busy_o); end
        alu_valid_i = 1'b1; alu_rd_ptr_i = 5'd9; alu_data_i = 32'h99;
        step();
        alu_valid_i = 1'b0;
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd9 || rd_o !== 32'h99) begin failures++; $display("FAIL x0_after got=%0b/%0d/%h exp=1/9/99", reg_write_en_o, rd_ptr_o, rd_o); end
        step();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL x0_busy_retired got=%0b exp=0", busy_o); end
    endtask

    task automatic test_waw;
        issue(5'd7);
        issue_rd_ptr_i = 5'd7;
        checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL waw_hazard0 got=%0b exp=1", hazard_o); end
        step();
        checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL waw_hazard1 got=%0b exp=1", hazard_o); end
        mem_valid_i = 1'b1; mem_rd_ptr_i = 5'd7; mem_data_i = 32'h77;
        step();
        mem_valid_i = 1'b0;
        checks++; if (reg_write_en_o !== 1'b1 || rd_ptr_o !== 5'd7 || rd_o !== 32'h77) begin failures++; $display("FAIL waw_write got=%0b/%0d/%h exp=1/7/77", reg_write_en_o, rd_ptr_o, rd_o); end
        checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL waw_hazard_pulse got=%0b exp=1", hazard_o); end
        step();
        checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL waw_hazard_retired got=%0b exp=0", hazard_o); end
        issue_rd_ptr_i = '0;
    endtask

    task automatic test_reset_mid_burst;
        issue(5'd3);
        issue(5'd4);
        alu_valid_i = 1'b1; alu_rd_ptr_i = 5'd3; alu_data_i = 32'h33;
        mem_valid_i = 1'b1; mem_rd_ptr_i = 5'd4; mem_data_i = 32'h44;
        step();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        checks++; if (reg_write_en_o !== 1'b1 || alu_ready_o !== 1'b0) begin failures++; $display("FAIL rmb_pre got=%0b/%0b exp=1/0", reg_write_en_o, alu_ready_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (reg_write_en_o !== 1'b0 || rd_ptr_o !== 5'd0 || rd_o !== 32'h0) begin failures++; $display("FAIL rmb_outputs got=%0b/%0d/%h exp=0/0/0", reg_write_en_o, rd_ptr_o, rd_o); end
        checks++; if (alu_ready_o !== 1'b1 || mem_ready_o !== 1'b1) begin failures++; $display("FAIL rmb_ready got=%0b%0b exp=11", alu_ready_o, mem_ready_o); end
        checks++; if (busy_o !== 1'b0 || hazard_o !== 1'b0) begin failures++; $display("FAIL rmb_sb got=%0b/%0b exp=0/0", busy_o, hazard_o); end
        step();
        rst_i = 1'b0;
        step();
        checks++; if (reg_write_en_o !== 1'b0) begin failures++; $display("FAIL rmb_skid_dropped0 got=%0b exp=0", reg_write_en_o); end
        step();
        checks++; if (reg_write_en_o !== 1'b0) begin failures++; $display("FAIL rmb_skid_dropped1 got=%0b exp=0", reg_write_en_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_alu_only();
        test_collision();
        test_starvation();
        test_back_to_back();
        test_x0();
        test_waw();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
